rs_age_select: RTL and testbench

//  Parametrised reservation station for the ALU path. Replaces the fixed single-broadcast RS.

---
 rtl/rs_age_select_pkg.sv | 12 +
 rtl/rs_age_select_age_matrix.sv | 46 ++++
 rtl/rs_age_select.sv | 186 ++++++++++++++++++
 tb/tb_rs_age_select.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_select_pkg.sv
// Shared defaults for the ALU reservation station.
// Sizes used by rs_age_select and rs_age_matrix.
package rs_age_select_pkg;

  localparam int RS_DEPTH    = 8;
  localparam int RS_ROB_BITS = 4;
  localparam int RS_NUM_CDB  = 2;
  localparam int RS_OP_W     = 6;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/rs_age_select_age_matrix.sv
// Age matrix for oldest-ready-first select.
// Ports: alloc/disp one-hot and eligible vector in, grant one-hot out.
module rs_age_matrix
  import rs_age_select_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [DEPTH-1:0] alloc_oh_in,
  input  logic [DEPTH-1:0] disp_oh_in,
  input  logic [DEPTH-1:0] elig_in,
  output logic [DEPTH-1:0] grant_out
);

  // age_q[j][i] = 1: entry j is older than entry i
  logic [DEPTH-1:0] age_q [DEPTH];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int j = 0; j < DEPTH; j++)
        age_q[j] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (alloc_oh_in[k]) begin
          for (int j = 0; j < DEPTH; j++)
            age_q[j][k] <= (j != k);
          age_q[k] <= '0;
        end else if (disp_oh_in[k]) begin
          age_q[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    grant_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      grant_out[i] = elig_in[i];
      for (int j = 0; j < DEPTH; j++)
        if (elig_in[j] && age_q[j][i])
          grant_out[i] = 1'b0;
    end
  end

endmodule

// File: rtl/rs_age_select.sv
// ALU reservation station: CDB wakeup, one dispatch per cycle.
// Define RS_AGE_ORDER_EN for oldest-first select, else lowest index.
module rs_age_select
  import rs_age_select_pkg::*;
#(
  parameter int DEPTH    = RS_DEPTH,
  parameter int ROB_BITS = RS_ROB_BITS,
  parameter int NUM_CDB  = RS_NUM_CDB,
  parameter int OP_W     = RS_OP_W,
  localparam int CW      = $clog2(DEPTH+1)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    flush_in,
  input  logic                    alloc_valid_in,
  output logic                    alloc_ready_out,
  input  logic [OP_W-1:0]         alloc_op_in,
  input  logic [ROB_BITS-1:0]     alloc_dest_in,
  input  logic [31:0]             alloc_imm_in,
  input  logic                    alloc_src1_rdy_in,
  input  logic [31:0]             alloc_src1_val_in,
  input  logic [ROB_BITS-1:0]     alloc_src1_tag_in,
  input  logic                    alloc_src2_rdy_in,
  input  logic [31:0]             alloc_src2_val_in,
  input  logic [ROB_BITS-1:0]     alloc_src2_tag_in,
  input  logic [NUM_CDB-1:0]      cdb_valid_in,
  input  logic [NUM_CDB*ROB_BITS-1:0] cdb_tag_in,
  input  logic [NUM_CDB*32-1:0]   cdb_value_in,
  output logic                    disp_valid_out,
  input  logic                    disp_ready_in,
  output logic [OP_W-1:0]         disp_op_out,
  output logic [31:0]             disp_vj_out,
  output logic [31:0]             disp_vk_out,
  output logic [31:0]             disp_imm_out,
  output logic [ROB_BITS-1:0]     disp_dest_out,
  output logic [CW-1:0]           count_out
);

  logic [DEPTH-1:0]    valid_q, rj_q, rk_q;
  logic [OP_W-1:0]     op_q   [DEPTH];
  logic [ROB_BITS-1:0] dest_q [DEPTH];
  logic [ROB_BITS-1:0] qj_q   [DEPTH];
  logic [ROB_BITS-1:0] qk_q   [DEPTH];
  word_t               vj_q   [DEPTH];
  word_t               vk_q   [DEPTH];
  word_t               imm_q  [DEPTH];
  logic [CW-1:0]       count_q;

  logic [DEPTH-1:0] elig, grant, free_oh;
  logic [DEPTH-1:0] alloc_oh, disp_oh;
  logic [DEPTH-1:0] wj_hit, wk_hit;
  word_t            wj_val [DEPTH];
  word_t            wk_val [DEPTH];
  logic             a1_hit, a2_hit;
  word_t            a1_val, a2_val;
  logic             alloc_fire, disp_fire;

  // Scan high to low so the lowest matching channel wins.
  function automatic logic [32:0] snoop(
    input logic [ROB_BITS-1:0]         tag,
    input logic [NUM_CDB-1:0]          cv,
    input logic [NUM_CDB*ROB_BITS-1:0] ct,
    input logic [NUM_CDB*32-1:0]       cval
  );
    logic [32:0] r;
    r = '0;
    for (int c = NUM_CDB-1; c >= 0; c--)
      if (cv[c] && ct[c*ROB_BITS +: ROB_BITS] == tag)
        r = {1'b1, cval[c*32 +: 32]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {wj_hit[i], wj_val[i]} = snoop(qj_q[i],
        cdb_valid_in, cdb_tag_in, cdb_value_in);
      {wk_hit[i], wk_val[i]} = snoop(qk_q[i],
        cdb_valid_in, cdb_tag_in, cdb_value_in);
    end
    {a1_hit, a1_val} = snoop(alloc_src1_tag_in,
      cdb_valid_in, cdb_tag_in, cdb_value_in);
    {a2_hit, a2_val} = snoop(alloc_src2_tag_in,
      cdb_valid_in, cdb_tag_in, cdb_value_in);
  end

  assign elig    = valid_q & rj_q & rk_q;
  assign free_oh = ~valid_q & (valid_q + DEPTH'(1));

  assign alloc_ready_out = (count_q != CW'(DEPTH));
  assign alloc_fire = alloc_valid_in & alloc_ready_out
                    & rdy_in & ~flush_in;
  assign disp_valid_out = (|elig) & rdy_in & ~flush_in;
  assign disp_fire = disp_valid_out & disp_ready_in;

  assign alloc_oh = free_oh & {DEPTH{alloc_fire}};
  assign disp_oh  = grant & {DEPTH{disp_fire}};
  assign count_out = count_q;

`ifdef RS_AGE_ORDER_EN
  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .alloc_oh_in (alloc_oh),
    .disp_oh_in  (disp_oh),
    .elig_in     (elig),
    .grant_out   (grant)
  );
`else
  assign grant = elig & (~elig + DEPTH'(1));
`endif

  always_comb begin
    disp_op_out   = '0;
    disp_vj_out   = '0;
    disp_vk_out   = '0;
    disp_imm_out  = '0;
    disp_dest_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        disp_op_out   = disp_op_out   | op_q[i];
        disp_vj_out   = disp_vj_out   | vj_q[i];
        disp_vk_out   = disp_vk_out   | vk_q[i];
        disp_imm_out  = disp_imm_out  | imm_q[i];
        disp_dest_out = disp_dest_out | dest_q[i];
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q <= '0;
      rj_q    <= '0;
      rk_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        dest_q[i] <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        imm_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_q <= '0;
        count_q <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (alloc_oh[i]) begin
            valid_q[i] <= 1'b1;
            op_q[i]    <= alloc_op_in;
            dest_q[i]  <= alloc_dest_in;
            imm_q[i]   <= alloc_imm_in;
            qj_q[i]    <= alloc_src1_tag_in;
            qk_q[i]    <= alloc_src2_tag_in;
            rj_q[i]    <= alloc_src1_rdy_in | a1_hit;
            rk_q[i]    <= alloc_src2_rdy_in | a2_hit;
            vj_q[i]    <= alloc_src1_rdy_in ?
                          alloc_src1_val_in : a1_val;
            vk_q[i]    <= alloc_src2_rdy_in ?
                          alloc_src2_val_in : a2_val;
          end else begin
            if (disp_oh[i])
              valid_q[i] <= 1'b0;
            if (valid_q[i] && !rj_q[i] && wj_hit[i]) begin
              rj_q[i] <= 1'b1;
              vj_q[i] <= wj_val[i];
            end
            if (valid_q[i] && !rk_q[i] && wk_hit[i]) begin
              rk_q[i] <= 1'b1;
              vk_q[i] <= wk_val[i];
            end
          end
        end
        unique case ({alloc_fire, disp_fire})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_age_select.sv
// Bench for rs_age_select: vector table, scoreboard of dispatches,
// and hand sequences for wakeup, full, age, flush and reset.
module tb_rs_age_select;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        alloc_valid_in;
  logic        alloc_ready_out;
  logic [5:0]  alloc_op_in;
  logic [3:0]  alloc_dest_in;
  logic [31:0] alloc_imm_in;
  logic        alloc_src1_rdy_in;
  logic [31:0] alloc_src1_val_in;
  logic [3:0]  alloc_src1_tag_in;
  logic        alloc_src2_rdy_in;
  logic [31:0] alloc_src2_val_in;
  logic [3:0]  alloc_src2_tag_in;
  logic [1:0]  cdb_valid_in;
  logic [7:0]  cdb_tag_in;
  logic [63:0] cdb_value_in;
  logic        disp_valid_out;
  logic        disp_ready_in;
  logic [5:0]  disp_op_out;
  logic [31:0] disp_vj_out;
  logic [31:0] disp_vk_out;
  logic [31:0] disp_imm_out;
  logic [3:0]  disp_dest_out;
  logic [3:0]  count_out;

  rs_age_select dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .rdy_in            (rdy_in),
    .flush_in          (flush_in),
    .alloc_valid_in    (alloc_valid_in),
    .alloc_ready_out   (alloc_ready_out),
    .alloc_op_in       (alloc_op_in),
    .alloc_dest_in     (alloc_dest_in),
    .alloc_imm_in      (alloc_imm_in),
    .alloc_src1_rdy_in (alloc_src1_rdy_in),
    .alloc_src1_val_in (alloc_src1_val_in),
    .alloc_src1_tag_in (alloc_src1_tag_in),
    .alloc_src2_rdy_in (alloc_src2_rdy_in),
    .alloc_src2_val_in (alloc_src2_val_in),
    .alloc_src2_tag_in (alloc_src2_tag_in),
    .cdb_valid_in      (cdb_valid_in),
    .cdb_tag_in        (cdb_tag_in),
    .cdb_value_in      (cdb_value_in),
    .disp_valid_out    (disp_valid_out),
    .disp_ready_in     (disp_ready_in),
    .disp_op_out       (disp_op_out),
    .disp_vj_out       (disp_vj_out),
    .disp_vk_out       (disp_vk_out),
    .disp_imm_out      (disp_imm_out),
    .disp_dest_out     (disp_dest_out),
    .count_out         (count_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic [31:0] imm;
    logic [3:0]  dest;
  } exp_t;

  typedef struct {
    logic        s1r;
    logic [31:0] s1v;
    logic [3:0]  s1t;
    logic        s2r;
    logic [31:0] s2v;
    logic [3:0]  s2t;
    logic [1:0]  cv;
    logic [3:0]  t0;
    logic [3:0]  t1;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] evj;
    logic [31:0] evk;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];
  exp_t sbq [$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [5:0] op,
                      input logic [31:0] vj,
                      input logic [31:0] vk,
                      input logic [31:0] imm,
                      input logic [3:0] dest);
    exp_t e;
    e.op = op; e.vj = vj; e.vk = vk;
    e.imm = imm; e.dest = dest;
    sbq.push_back(e);
  endtask

  task automatic alloc(input logic [5:0] op,
                       input logic [3:0] dest,
                       input logic [31:0] imm,
                       input logic r1,
                       input logic [31:0] v1,
                       input logic [3:0] t1,
                       input logic r2,
                       input logic [31:0] v2,
                       input logic [3:0] t2);
    alloc_valid_in    = 1'b1;
    alloc_op_in       = op;
    alloc_dest_in     = dest;
    alloc_imm_in      = imm;
    alloc_src1_rdy_in = r1;
    alloc_src1_val_in = v1;
    alloc_src1_tag_in = t1;
    alloc_src2_rdy_in = r2;
    alloc_src2_val_in = v2;
    alloc_src2_tag_in = t2;
  endtask

  always @(negedge clk_in) begin
    if (mon_en && rst_n_in && disp_valid_out && disp_ready_in) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_disp actual dest=%0h required none",
                 disp_dest_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("disp_op", 64'(disp_op_out), 64'(e.op));
        chk("disp_vj", 64'(disp_vj_out), 64'(e.vj));
        chk("disp_vk", 64'(disp_vk_out), 64'(e.vk));
        chk("disp_imm", 64'(disp_imm_out), 64'(e.imm));
        chk("disp_dest", 64'(disp_dest_out), 64'(e.dest));
      end
    end
  end

  initial begin
    vec[0] = '{1'b1, 32'h100, 4'd0, 1'b1, 32'h200, 4'd0,
               2'b00, 4'd0, 4'd0, 32'h0, 32'h0,
               32'h100, 32'h200};
    vec[1] = '{1'b0, 32'h0, 4'd5, 1'b1, 32'h22, 4'd0,
               2'b10, 4'd5, 4'd5, 32'h1111, 32'hDEAD,
               32'hDEAD, 32'h22};
    vec[2] = '{1'b1, 32'h7, 4'd0, 1'b0, 32'h0, 4'd3,
               2'b11, 4'd3, 4'd3, 32'h33, 32'h44,
               32'h7, 32'h33};
    vec[3] = '{1'b0, 32'h0, 4'd6, 1'b0, 32'h0, 4'd2,
               2'b11, 4'd2, 4'd6, 32'h22, 32'h66,
               32'h66, 32'h22};
    vec[4] = '{1'b1, 32'hAA, 4'd4, 1'b0, 32'h0, 4'd4,
               2'b01, 4'd4, 4'd0, 32'hBB, 32'h0,
               32'hAA, 32'hBB};
    vec[5] = '{1'b0, 32'h0, 4'd9, 1'b0, 32'h0, 4'd9,
               2'b10, 4'd1, 4'd9, 32'h5, 32'h99,
               32'h99, 32'h99};

    rst_n_in = 1'b0;
    rdy_in = 1'b1;
    flush_in = 1'b0;
    disp_ready_in = 1'b0;
    cdb_valid_in = '0;
    cdb_tag_in = '0;
    cdb_value_in = '0;
    alloc(6'd0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0,
          1'b0, 32'd0, 4'd0);
    alloc_valid_in = 1'b0;

    repeat (2) step();
    chk("rst_count", 64'(count_out), 64'd0);
    chk("rst_disp_valid", 64'(disp_valid_out), 64'd0);
    chk("rst_alloc_ready", 64'(alloc_ready_out), 64'd1);
    chk("rst_disp_vj", 64'(disp_vj_out), 64'd0);
    rst_n_in = 1'b1;
    mon_en = 1'b1;

    // Table: one alloc per cycle, each dispatched the next cycle.
    disp_ready_in = 1'b1;
    for (int i = 0; i < NV; i++) begin
      step();
      alloc(6'(i + 1), 4'(i), 32'(i * 100),
            vec[i].s1r, vec[i].s1v, vec[i].s1t,
            vec[i].s2r, vec[i].s2v, vec[i].s2t);
      cdb_valid_in = vec[i].cv;
      cdb_tag_in   = {vec[i].t1, vec[i].t0};
      cdb_value_in = {vec[i].v1, vec[i].v0};
      push(6'(i + 1), vec[i].evj, vec[i].evk,
           32'(i * 100), 4'(i));
      @(negedge clk_in);
      chk("tbl_disp_timing", 64'(disp_valid_out),
          64'(i > 0));
    end
    step();
    alloc_valid_in = 1'b0;
    cdb_valid_in = '0;
    @(negedge clk_in);
    chk("tbl_last_valid", 64'(disp_valid_out), 64'd1);
    step();
    @(negedge clk_in);
    chk("tbl_drained_valid", 64'(disp_valid_out), 64'd0);
    chk("tbl_drained_count", 64'(count_out), 64'd0);

    // Wakeup: src2 waits for tag 3 broadcast two cycles later.
    step();
    alloc(6'h7, 4'd3, 32'h5, 1'b1, 32'h11, 4'd0,
          1'b0, 32'h0, 4'd3);
    push(6'h7, 32'h11, 32'h7, 32'h5, 4'd3);
    @(negedge clk_in);
    chk("wake_alloc_cyc", 64'(disp_valid_out), 64'd0);
    step();
    alloc_valid_in = 1'b0;
    @(negedge clk_in);
    chk("wake_wait", 64'(disp_valid_out), 64'd0);
    step();
    cdb_valid_in = 2'b01;
    cdb_tag_in = {4'd0, 4'd3};
    cdb_value_in = {32'h0, 32'h7};
    @(negedge clk_in);
    chk("wake_bcast_cyc", 64'(disp_valid_out), 64'd0);
    step();
    cdb_valid_in = '0;
    @(negedge clk_in);
    chk("wake_ready", 64'(disp_valid_out), 64'd1);
    chk("wake_vk", 64'(disp_vk_out), 64'd7);
    step();
    @(negedge clk_in);
    chk("wake_count", 64'(count_out), 64'd0);

    // Full: fill eight slots with the ALU stalled.
    disp_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      alloc(6'(i), 4'(i), 32'(i), 1'b1, 32'(32'h1000 + i),
            4'd0, 1'b1, 32'(32'h2000 + i), 4'd0);
      push(6'(i), 32'(32'h1000 + i), 32'(32'h2000 + i),
           32'(i), 4'(i));
    end
    step();
    alloc_valid_in = 1'b0;
    @(negedge clk_in);
    chk("full_count8", 64'(count_out), 64'd8);
    chk("full_alloc_ready", 64'(alloc_ready_out), 64'd0);
    chk("full_disp_valid", 64'(disp_valid_out), 64'd1);
    step();
    rdy_in = 1'b0;
    disp_ready_in = 1'b1;
    @(negedge clk_in);
    chk("pause_disp_valid", 64'(disp_valid_out), 64'd0);
    step();
    rdy_in = 1'b1;
    alloc(6'h3F, 4'hF, 32'hFFFF, 1'b1, 32'h1, 4'd0,
          1'b1, 32'h2, 4'd0);
    @(negedge clk_in);
    chk("pause_count_hold", 64'(count_out), 64'd8);
    chk("full_refuse", 64'(alloc_ready_out), 64'd0);
    step();
    alloc_valid_in = 1'b0;
    @(negedge clk_in);
    chk("full_count7", 64'(count_out), 64'd7);
    chk("full_ready_again", 64'(alloc_ready_out), 64'd1);
    repeat (8) step();
    @(negedge clk_in);
    chk("full_drain_count", 64'(count_out), 64'd0);
    chk("full_no_phantom", 64'(disp_valid_out), 64'd0);

    // Age: A pending in slot0, B ready in slot1, then C into slot0.
    disp_ready_in = 1'b0;
    step();
    alloc(6'h21, 4'd1, 32'h0, 1'b0, 32'h0, 4'd9,
          1'b1, 32'h2, 4'd0);
    push(6'h21, 32'hA, 32'h2, 32'h0, 4'd1);
    step();
    alloc(6'h22, 4'd2, 32'h0, 1'b1, 32'hB, 4'd0,
          1'b1, 32'hB2, 4'd0);
    step();
    alloc_valid_in = 1'b0;
    cdb_valid_in = 2'b01;
    cdb_tag_in = {4'd0, 4'd9};
    cdb_value_in = {32'h0, 32'hA};
    step();
    cdb_valid_in = '0;
    disp_ready_in = 1'b1;
    @(negedge clk_in);
    chk("age_first_a", 64'(disp_dest_out), 64'd1);
    step();
    disp_ready_in = 1'b0;
    alloc(6'h23, 4'd3, 32'h0, 1'b1, 32'hC, 4'd0,
          1'b1, 32'hC2, 4'd0);
`ifdef RS_AGE_ORDER_EN
    push(6'h22, 32'hB, 32'hB2, 32'h0, 4'd2);
    push(6'h23, 32'hC, 32'hC2, 32'h0, 4'd3);
`else
    push(6'h23, 32'hC, 32'hC2, 32'h0, 4'd3);
    push(6'h22, 32'hB, 32'hB2, 32'h0, 4'd2);
`endif
    @(negedge clk_in);
    chk("age_count_b", 64'(count_out), 64'd1);
    step();
    alloc_valid_in = 1'b0;
    disp_ready_in = 1'b1;
    @(negedge clk_in);
`ifdef RS_AGE_ORDER_EN
    chk("age_order", 64'(disp_dest_out), 64'd2);
`else
    chk("age_order", 64'(disp_dest_out), 64'd3);
`endif
    repeat (2) step();
    @(negedge clk_in);
    chk("age_count_end", 64'(count_out), 64'd0);

    // Flush with four held entries and a same-cycle alloc.
    disp_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      alloc(6'(i), 4'(i), 32'h0, 1'b1, 32'h1, 4'd0,
            1'b1, 32'h2, 4'd0);
    end
    step();
    flush_in = 1'b1;
    alloc(6'h9, 4'd9, 32'h9, 1'b1, 32'h9, 4'd0,
          1'b1, 32'h9, 4'd0);
    @(negedge clk_in);
    chk("flush_disp_valid", 64'(disp_valid_out), 64'd0);
    chk("flush_pre_count", 64'(count_out), 64'd4);
    step();
    flush_in = 1'b0;
    alloc_valid_in = 1'b0;
    disp_ready_in = 1'b1;
    @(negedge clk_in);
    chk("flush_count", 64'(count_out), 64'd0);
    chk("flush_no_entry", 64'(disp_valid_out), 64'd0);
    repeat (2) step();

    // Asynchronous reset with three held entries.
    disp_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      alloc(6'(i), 4'(i), 32'h0, 1'b1, 32'h1, 4'd0,
            1'b1, 32'h2, 4'd0);
    end
    step();
    alloc_valid_in = 1'b0;
    @(negedge clk_in);
    chk("arst_pre_count", 64'(count_out), 64'd3);
    #2;
    rst_n_in = 1'b0;
    #1;
    chk("arst_count", 64'(count_out), 64'd0);
    chk("arst_disp_valid", 64'(disp_valid_out), 64'd0);
    chk("arst_alloc_ready", 64'(alloc_ready_out), 64'd1);
    step();
    rst_n_in = 1'b1;
    step();
    @(negedge clk_in);
    chk("arst_after", 64'(count_out), 64'd0);

    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
